muldiv_unit: RTL and testbench

- Iterative multiply/divide unit for MULT, MULTU, DIV and DIVU.
- Sits in EX beside the ALU. Takes forwarded rs/rt operands and produces the 64-bit {HI,LO} result, which is carried to ME/WB and written into the HI/LO registers.
- Requests a pipeline stall while an operation is in flight; the hazard unit holds IF/ID/EX until done.

---
 rtl/muldiv_unit.sv | 191 +++++++++++++++++++
 tb/tb_muldiv_unit.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit for the EX stage.
// Produces the 64-bit {hi,lo} result and stalls the pipeline while an operation is in flight.
module muldiv_unit #(
    parameter int unsigned MUL_CYCLES = 2,
    parameter int unsigned DIV_ITERS  = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic        flush,
    input  logic [31:0] srca,
    input  logic [31:0] srcb,
    output logic        stall,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int unsigned MulCntW = $clog2(MUL_CYCLES + 1);
    localparam int unsigned DivCntW = $clog2(DIV_ITERS + 1);
    localparam int unsigned CntW    = (MulCntW > DivCntW) ? MulCntW : DivCntW;

    typedef enum logic [1:0] {StIdle, StMul, StDiv, StFin} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [31:0]       rem_q, rem_d;
    logic [31:0]       quo_q, quo_d;
    logic [31:0]       dvsr_q, dvsr_d;
    logic [31:0]       araw_q, araw_d;
    logic              qneg_q, qneg_d;
    logic              rneg_q, rneg_d;
    logic              dvz_q, dvz_d;
    logic [31:0]       hi_q, hi_d;
    logic [31:0]       lo_q, lo_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              is_div;
    logic              is_signed;
    logic [31:0]       a_abs;
    logic [31:0]       b_abs;
    logic [63:0]       a_ext;
    logic [63:0]       b_ext;
    logic [63:0]       prod;
    logic [32:0]       trial;

    assign is_div    = op[1];
    assign is_signed = ~op[0];
    assign a_abs     = (is_signed && srca[31]) ? -srca : srca;
    assign b_abs     = (is_signed && srcb[31]) ? -srcb : srcb;
    assign a_ext     = {{32{is_signed & srca[31]}}, srca};
    assign b_ext     = {{32{is_signed & srcb[31]}}, srcb};
    assign prod      = a_ext * b_ext;

    // Restoring step: bit 32 set means the shifted remainder was smaller than the divisor.
    assign trial = {rem_q, quo_q[31]} - {1'b0, dvsr_q};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvsr_d  = dvsr_q;
        araw_d  = araw_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        dvz_d   = dvz_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        if (flush) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        cnt_d = '0;
                        if (is_div) begin
                            state_d = StDiv;
                            busy_d  = 1'b1;
                            rem_d   = '0;
                            quo_d   = a_abs;
                            dvsr_d  = b_abs;
                            araw_d  = srca;
                            qneg_d  = is_signed & (srca[31] ^ srcb[31]);
                            rneg_d  = is_signed & srca[31];
                            dvz_d   = (srcb == 32'd0);
                        end else begin
                            rem_d = prod[63:32];
                            quo_d = prod[31:0];
                            cnt_d = CntW'(1);
                            if (MUL_CYCLES <= 1) begin
                                state_d = StFin;
                                done_d  = 1'b1;
                                hi_d    = prod[63:32];
                                lo_d    = prod[31:0];
                            end else begin
                                state_d = StMul;
                                busy_d  = 1'b1;
                            end
                        end
                    end
                end
                StMul: begin
                    if (cnt_q >= CntW'(MUL_CYCLES - 1)) begin
                        state_d = StFin;
                        done_d  = 1'b1;
                        hi_d    = rem_q;
                        lo_d    = quo_q;
                    end else begin
                        busy_d = 1'b1;
                        cnt_d  = cnt_q + CntW'(1);
                    end
                end
                StDiv: begin
                    if (cnt_q < CntW'(DIV_ITERS)) begin
                        busy_d = 1'b1;
                        cnt_d  = cnt_q + CntW'(1);
                        if (!trial[32]) begin
                            rem_d = trial[31:0];
                            quo_d = {quo_q[30:0], 1'b1};
                        end else begin
                            rem_d = {rem_q[30:0], quo_q[31]};
                            quo_d = {quo_q[30:0], 1'b0};
                        end
                    end else begin
                        state_d = StFin;
                        done_d  = 1'b1;
                        if (dvz_q) begin
                            hi_d = araw_q;
                            lo_d = 32'hFFFF_FFFF;
                        end else begin
                            hi_d = rneg_q ? -rem_q : rem_q;
                            lo_d = qneg_q ? -quo_q : quo_q;
                        end
                    end
                end
                StFin: begin
                    state_d = StIdle;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvsr_q  <= '0;
            araw_q  <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            dvz_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvsr_q  <= dvsr_d;
            araw_q  <= araw_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            dvz_q   <= dvz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign stall = start & ~done_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign hi    = hi_q;
    assign lo    = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: scoreboard of expected {hi,lo,latency} per issued op.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic        flush;
    logic [31:0] srca;
    logic [31:0] srcb;
    logic        stall;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    int          total_cnt = 0;
    int          pass_cnt  = 0;
    logic [31:0] prev_hi   = 32'd0;
    logic [31:0] prev_lo   = 32'd0;

    muldiv_unit dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .flush (flush),
        .srca  (srca),
        .srcb  (srcb),
        .stall (stall),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

    // Drives one op and waits (bounded) for done. If called during a done cycle, the op is
    // accepted in the following IDLE cycle; dbl reports done still high there.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input bit keep, output int lat, output bit busy_ok,
                          output logic st, output logic dbl,
                          output logic [31:0] h, output logic [31:0] l);
        start = 1'b1;
        op    = o;
        srca  = a;
        srcb  = b;
        dbl   = 1'b0;
        if (done) begin
            @(posedge clk);
            #1;
            dbl = done;
        end
        lat     = -1;
        busy_ok = 1'b1;
        st      = 1'bx;
        h       = 32'hx;
        l       = 32'hx;
        for (int c = 1; c <= 100; c++) begin
            @(posedge clk);
            #1;
            if (c == 1) begin
                srca = $urandom;
                srcb = $urandom;
            end
            if (done) begin
                lat = c;
                st  = stall;
                h   = hi;
                l   = lo;
                break;
            end
            if (busy !== 1'b1) busy_ok = 1'b0;
        end
        if (!keep) start = 1'b0;
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b1;
        op    = 2'b10;
        flush = 1'b0;
        srca  = 32'd50;
        srcb  = 32'd5;
        repeat (3) @(posedge clk);
        #1;
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
        total_cnt++;
        if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else pass_cnt++;
        total_cnt++;
        if (hi !== 32'd0) $display("FAIL reset_hi: got %h want 0", hi); else pass_cnt++;
        total_cnt++;
        if (lo !== 32'd0) $display("FAIL reset_lo: got %h want 0", lo); else pass_cnt++;
        rst   = 1'b0;
        start = 1'b0;
        @(posedge clk);
        #1;
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL idle_busy: got %b want 0", busy); else pass_cnt++;
    endtask

    task automatic test_mult();
        exp_t        e;
        int          lat;
        bit          bok;
        logic        st, dbl;
        logic [31:0] h, l;
        logic [1:0]  ops[2] = '{2'b00, 2'b01};
        exp_t        exps[2] = '{'{hi: 32'hFFFF_FFFF, lo: 32'hFFFF_FFEB, lat: 2},
                                 '{hi: 32'h0000_0006, lo: 32'hFFFF_FFEB, lat: 2}};
        for (int i = 0; i < 2; i++) begin
            sb.push_back(exps[i]);
            run_op(ops[i], 32'hFFFF_FFFD, 32'd7, 1'b0, lat, bok, st, dbl, h, l);
            e = sb.pop_front();
            total_cnt++;
            if (lat !== e.lat) $display("FAIL mult%0d_lat: got %0d want %0d", i, lat, e.lat);
            else pass_cnt++;
            total_cnt++;
            if (!bok) $display("FAIL mult%0d_busy: got busy low want high", i); else pass_cnt++;
            total_cnt++;
            if (h !== e.hi) $display("FAIL mult%0d_hi: got %h want %h", i, h, e.hi);
            else pass_cnt++;
            total_cnt++;
            if (l !== e.lo) $display("FAIL mult%0d_lo: got %h want %h", i, l, e.lo);
            else pass_cnt++;
            prev_hi = e.hi;
            prev_lo = e.lo;
        end
    endtask

    task automatic test_div();
        exp_t        e;
        int          lat;
        bit          bok;
        logic        st, dbl;
        logic [31:0] h, l;
        logic [1:0]  ops[2] = '{2'b10, 2'b11};
        exp_t        exps[2] = '{'{hi: 32'hFFFF_FFFF, lo: 32'hFFFF_FFFD, lat: 34},
                                 '{hi: 32'h0000_0001, lo: 32'h7FFF_FFFC, lat: 34}};
        for (int i = 0; i < 2; i++) begin
            sb.push_back(exps[i]);
            run_op(ops[i], 32'hFFFF_FFF9, 32'd2, 1'b0, lat, bok, st, dbl, h, l);
            e = sb.pop_front();
            total_cnt++;
            if (lat !== e.lat) $display("FAIL div%0d_lat: got %0d want %0d", i, lat, e.lat);
            else pass_cnt++;
            total_cnt++;
            if (!bok) $display("FAIL div%0d_busy: got busy low want high", i); else pass_cnt++;
            total_cnt++;
            if (st !== 1'b0) $display("FAIL div%0d_stall: got %b want 0", i, st); else pass_cnt++;
            total_cnt++;
            if (h !== e.hi) $display("FAIL div%0d_hi: got %h want %h", i, h, e.hi);
            else pass_cnt++;
            total_cnt++;
            if (l !== e.lo) $display("FAIL div%0d_lo: got %h want %h", i, l, e.lo);
            else pass_cnt++;
            prev_hi = e.hi;
            prev_lo = e.lo;
        end
    endtask

    task automatic test_corner_div();
        exp_t        e;
        int          lat;
        bit          bok;
        logic        st, dbl;
        logic [31:0] h, l;
        logic [1:0]  ops[2] = '{2'b11, 2'b10};
        logic [31:0] as[2]  = '{32'd5, 32'h8000_0000};
        logic [31:0] bs[2]  = '{32'd0, 32'hFFFF_FFFF};
        exp_t        exps[2] = '{'{hi: 32'd5, lo: 32'hFFFF_FFFF, lat: 34},
                                 '{hi: 32'd0, lo: 32'h8000_0000, lat: 34}};
        for (int i = 0; i < 2; i++) begin
            sb.push_back(exps[i]);
            run_op(ops[i], as[i], bs[i], 1'b0, lat, bok, st, dbl, h, l);
            e = sb.pop_front();
            total_cnt++;
            if (lat !== e.lat) $display("FAIL corner%0d_lat: got %0d want %0d", i, lat, e.lat);
            else pass_cnt++;
            total_cnt++;
            if (h !== e.hi) $display("FAIL corner%0d_hi: got %h want %h", i, h, e.hi);
            else pass_cnt++;
            total_cnt++;
            if (l !== e.lo) $display("FAIL corner%0d_lo: got %h want %h", i, l, e.lo);
            else pass_cnt++;
            prev_hi = e.hi;
            prev_lo = e.lo;
        end
    endtask

    task automatic test_flush();
        exp_t        e;
        int          lat;
        bit          bok;
        logic        st, dbl;
        logic [31:0] h, l;
        bit          saw_done = 1'b0;
        start = 1'b1;
        op    = 2'b10;
        srca  = 32'd100;
        srcb  = 32'd3;
        if (done) begin
            @(posedge clk);
            #1;
        end
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk);
            #1;
            if (done) saw_done = 1'b1;
        end
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        start = 1'b0;
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL flush_busy: got %b want 0", busy); else pass_cnt++;
        total_cnt++;
        if (hi !== prev_hi) $display("FAIL flush_hi: got %h want %h", hi, prev_hi);
        else pass_cnt++;
        total_cnt++;
        if (lo !== prev_lo) $display("FAIL flush_lo: got %h want %h", lo, prev_lo);
        else pass_cnt++;
        for (int c = 0; c < 40; c++) begin
            if (done) saw_done = 1'b1;
            @(posedge clk);
            #1;
        end
        total_cnt++;
        if (saw_done) $display("FAIL flush_nodone: got done pulse want none"); else pass_cnt++;
        sb.push_back('{hi: 32'd0, lo: 32'd12, lat: 2});
        run_op(2'b01, 32'd3, 32'd4, 1'b0, lat, bok, st, dbl, h, l);
        e = sb.pop_front();
        total_cnt++;
        if (lat !== e.lat) $display("FAIL flush_mul_lat: got %0d want %0d", lat, e.lat);
        else pass_cnt++;
        total_cnt++;
        if (h !== e.hi) $display("FAIL flush_mul_hi: got %h want %h", h, e.hi); else pass_cnt++;
        total_cnt++;
        if (l !== e.lo) $display("FAIL flush_mul_lo: got %h want %h", l, e.lo); else pass_cnt++;
        prev_hi = e.hi;
        prev_lo = e.lo;
    endtask

    task automatic test_reset_mid();
        start = 1'b1;
        op    = 2'b10;
        srca  = 32'd1000;
        srcb  = 32'd7;
        if (done) begin
            @(posedge clk);
            #1;
        end
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst   = 1'b0;
        start = 1'b0;
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL rstmid_busy: got %b want 0", busy); else pass_cnt++;
        total_cnt++;
        if (done !== 1'b0) $display("FAIL rstmid_done: got %b want 0", done); else pass_cnt++;
        total_cnt++;
        if (hi !== 32'd0) $display("FAIL rstmid_hi: got %h want 0", hi); else pass_cnt++;
        total_cnt++;
        if (lo !== 32'd0) $display("FAIL rstmid_lo: got %h want 0", lo); else pass_cnt++;
        prev_hi = 32'd0;
        prev_lo = 32'd0;
    endtask

    task automatic test_back_to_back();
        exp_t        e;
        int          lat;
        bit          bok;
        logic        st, dbl;
        logic [31:0] h, l;
        sb.push_back('{hi: 32'd0, lo: 32'd6, lat: 2});
        run_op(2'b00, 32'd2, 32'd3, 1'b1, lat, bok, st, dbl, h, l);
        e = sb.pop_front();
        total_cnt++;
        if (lat !== e.lat) $display("FAIL b2b_mul_lat: got %0d want %0d", lat, e.lat);
        else pass_cnt++;
        total_cnt++;
        if (h !== e.hi || l !== e.lo)
            $display("FAIL b2b_mul_res: got %h_%h want %h_%h", h, l, e.hi, e.lo);
        else pass_cnt++;
        sb.push_back('{hi: 32'd1, lo: 32'd2, lat: 34});
        run_op(2'b11, 32'd9, 32'd4, 1'b0, lat, bok, st, dbl, h, l);
        e = sb.pop_front();
        total_cnt++;
        if (dbl !== 1'b0) $display("FAIL b2b_single_pulse: got done=%b want 0", dbl);
        else pass_cnt++;
        total_cnt++;
        if (lat !== e.lat) $display("FAIL b2b_div_lat: got %0d want %0d", lat, e.lat);
        else pass_cnt++;
        total_cnt++;
        if (h !== e.hi) $display("FAIL b2b_div_hi: got %h want %h", h, e.hi); else pass_cnt++;
        total_cnt++;
        if (l !== e.lo) $display("FAIL b2b_div_lo: got %h want %h", l, e.lo); else pass_cnt++;
        @(posedge clk);
        #1;
        total_cnt++;
        if (done !== 1'b0) $display("FAIL b2b_done_drop: got %b want 0", done); else pass_cnt++;
        prev_hi = e.hi;
        prev_lo = e.lo;
    endtask

    task automatic test_random();
        exp_t              e, m;
        int                lat;
        bit                bok;
        logic              st, dbl;
        logic [31:0]       h, l, a, b;
        logic [1:0]        o;
        logic [63:0]       p;
        logic signed [31:0] sq, sr;
        for (int i = 0; i < 8; i++) begin
            o = 2'(i % 4);
            a = $urandom;
            b = $urandom;
            if (b == 32'hFFFF_FFFF) b = 32'd5;
            if (i == 6) b = 32'd0;
            unique case (o)
                2'b00: p = 64'($signed(a)) * 64'($signed(b));
                2'b01: p = {32'd0, a} * {32'd0, b};
                2'b10: begin
                    if (b != 32'd0) begin
                        sq = $signed(a) / $signed(b);
                        sr = $signed(a) % $signed(b);
                        p  = {sr, sq};
                    end else p = {a, 32'hFFFF_FFFF};
                end
                default: p = (b != 32'd0) ? {a % b, a / b} : {a, 32'hFFFF_FFFF};
            endcase
            m.hi  = p[63:32];
            m.lo  = p[31:0];
            m.lat = o[1] ? 34 : 2;
            sb.push_back(m);
            run_op(o, a, b, 1'b0, lat, bok, st, dbl, h, l);
            e = sb.pop_front();
            total_cnt++;
            if (lat !== e.lat || h !== e.hi || l !== e.lo)
                $display("FAIL rand%0d op%0d %h,%h: got lat %0d %h_%h want lat %0d %h_%h",
                         i, o, a, b, lat, h, l, e.lat, e.hi, e.lo);
            else pass_cnt++;
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        op    = 2'b00;
        flush = 1'b0;
        srca  = 32'd0;
        srcb  = 32'd0;
        @(posedge clk);
        #1;
        test_reset();
        test_mult();
        test_div();
        test_corner_div();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        test_random();
        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
